if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1 bit, the hazard-unit hold request that keeps the IF/ID contents.
REQ-005 The block SHALL have port redirect, input, 1 bit, asserted when a branch or jump is resolved taken.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits, the taken target, valid while redirect=1.
REQ-007 The block SHALL have port imem_req, output, 1 bit, the instruction-memory request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits, the fetch address.
REQ-009 The block SHALL have port imem_ready, input, 1 bit, a one-cycle response strobe from instruction memory.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits, the instruction word, valid when imem_ready=1.
REQ-011 The block SHALL have port instruction, output, 32 bits, the fetched word presented to IF/ID.
REQ-012 The block SHALL have port adder1, output, 32 bits, the fetch PC+4 presented to IF/ID.
REQ-013 The block SHALL have port ifid_load, output, 1 bit, the IF/ID load enable.
REQ-014 The block SHALL have port ifid_flush, output, 1 bit, the IF/ID flush strobe.

Function
REQ-015 The block SHALL keep registers pc, pending_pc and hold_inst, and a state machine with states FETCH, HOLD and DRAIN.
REQ-016 The memory protocol SHALL be: once asserted, imem_req stays high with imem_addr stable until imem_ready=1; imem_ready may come in the same cycle as imem_req or any later cycle; memory never raises imem_ready without imem_req.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-018 In HOLD, imem_req SHALL be 0.
REQ-019 In DRAIN, imem_req SHALL be 1 and imem_addr SHALL equal pc, which is the old address.
REQ-020 instruction SHALL equal imem_rdata in FETCH and hold_inst in HOLD; adder1 SHALL equal pc+4 modulo 2^32, with wrap 32'hFFFF_FFFC -> 0 and no overflow flag.
REQ-021 In FETCH with imem_ready=1, redirect=0 and stall=0, the block SHALL set ifid_load=1 and pc<=pc+4, and stay in FETCH (zero-bubble, one instruction per response).
REQ-022 In FETCH with imem_ready=1, redirect=0 and stall=1, the block SHALL set ifid_load=0 and hold_inst<=imem_rdata, and go to HOLD.
REQ-023 In FETCH with imem_ready=0, the block SHALL set ifid_load=0; stall alone has no other effect and the request stays outstanding.
REQ-024 In HOLD with stall=1, ifid_load SHALL be 0; in HOLD with stall=0, ifid_load SHALL be 1, with pc<=pc+4 and a move to FETCH.
REQ-025 A redirect in FETCH with imem_ready=1, or in HOLD, SHALL discard the response or held word, set ifid_load=0 and ifid_flush=1, load pc<=redirect_pc, and go to FETCH.
REQ-026 A redirect in FETCH with imem_ready=0 SHALL set ifid_flush=1 and ifid_load=0, capture pending_pc<=redirect_pc, and go to DRAIN.
REQ-027 In DRAIN, the block SHALL keep ifid_load=0 and discard imem_rdata; on imem_ready=1 it SHALL load pc<=pending_pc and go to FETCH.
REQ-028 A redirect in DRAIN SHALL overwrite pending_pc with the newest target and pulse ifid_flush=1.
REQ-029 redirect SHALL have priority over stall; redirect with stall asserted together behaves as redirect alone.
REQ-030 ifid_flush SHALL be 1 only in a cycle with redirect=1; ifid_load and ifid_flush SHALL never both be 1.
REQ-031 All outputs SHALL be combinational from state, registers and inputs; latency from imem_ready to ifid_load SHALL be 0 cycles.

Reset
REQ-032 While reset=1, the block SHALL hold imem_req=0, ifid_load=0 and ifid_flush=0.
REQ-033 At the reset edge, the block SHALL set pc<=RESET_PC, pending_pc<=RESET_PC, hold_inst<=0 and state<=FETCH.
REQ-034 Reset SHALL override redirect, stall and imem_ready in the same cycle.
REQ-035 On reset mid-request, the outstanding response SHALL be abandoned; the memory model is reset alongside.
REQ-036 The first imem_req SHALL appear in the cycle after reset deasserts, with imem_addr=RESET_PC.

Verification
REQ-037 Reset, then imem_ready=1 every cycle with rdata=addr -> addresses 0,4,8,12; ifid_load=1 each cycle; adder1=4,8,12,16.
REQ-038 imem_ready delayed 3 cycles at addr 8 -> imem_req/addr=8 held 4 cycles; ifid_load=0 for 3 cycles, then 1 with adder1=12.
REQ-039 stall=1 for 2 cycles on the response at addr 4, with rdata=32'hDEAD_BEEF -> HOLD with imem_req=0 and instruction=32'hDEAD_BEEF; on release, ifid_load=1 and the next imem_addr=8.
REQ-040 redirect=1 with redirect_pc=32'h100 while the addr-8 request is pending -> ifid_flush pulse, DRAIN until imem_ready, response discarded, next imem_addr=32'h100.
REQ-041 redirect and stall together in HOLD with redirect_pc=32'h40 -> ifid_flush=1, ifid_load=0, next imem_addr=32'h40.
REQ-042 pc=32'hFFFF_FFFC fetched -> adder1=0 and next imem_addr=0; reset asserted mid-DRAIN -> imem_req=0, then imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch stage with stall hold and redirect drain.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] adder1,
    output logic        ifid_load,
    output logic        ifid_flush
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pending_pc_q <= RESET_PC;
            hold_inst_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            hold_inst_q  <= hold_inst_d;
        end
    end

    assign adder1 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        hold_inst_d  = hold_inst_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        instruction  = imem_rdata;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect) begin
                        ifid_flush = 1'b1;
                        pc_d       = redirect_pc;
                    end else if (stall) begin
                        hold_inst_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = adder1;
                    end
                end else if (redirect) begin
                    // Request already in flight: wait it out before refetching.
                    ifid_flush   = 1'b1;
                    pending_pc_d = redirect_pc;
                    state_d      = DRAIN;
                end
            end
            HOLD: begin
                instruction = hold_inst_q;
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = redirect_pc;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = adder1;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect) begin
                    ifid_flush   = 1'b1;
                    pending_pc_d = redirect_pc;
                end
                if (imem_ready) begin
                    // The newest target wins even when it arrives with the response.
                    pc_d    = redirect ? redirect_pc : pending_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (reset) begin
            imem_req   = 1'b0;
            ifid_load  = 1'b0;
            ifid_flush = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed and random checks of if_fetch_unit against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, ifid_load, ifid_flush;
    logic [31:0] imem_addr, instruction, adder1;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: where the next fetch goes and what is parked.
    logic [31:0] m_pc;
    logic        m_pc_known  = 1'b0;
    logic        m_held      = 1'b0;
    logic [31:0] m_word      = 32'h0;
    logic        m_wait      = 1'b0;
    logic [31:0] m_target    = 32'h0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock      (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .adder1     (adder1),
        .ifid_load  (ifid_load),
        .ifid_flush (ifid_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance model.
    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic rdy, input logic [31:0] rdat);
        logic e_req, e_load, e_flush, rdy_eff;
        e_req   = !r && !m_held;
        rdy_eff = rdy && e_req;
        e_flush = !r && rd;
        e_load  = !r && !rd && !s && !m_wait && (m_held || rdy_eff);
        reset = r; stall = s; redirect = rd; redirect_pc = rpc;
        imem_ready = rdy_eff; imem_rdata = rdat;
        #3;
        check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        check("ifid_load", {31'd0, ifid_load}, {31'd0, e_load});
        check("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_flush});
        if (!r && m_pc_known) begin
            check("adder1", adder1, m_pc + 32'd4);
            if (e_req) check("imem_addr", imem_addr, m_pc);
        end
        if (e_load) check("instruction", instruction, m_held ? m_word : rdat);
        else if (!r && m_held) check("held_instruction", instruction, m_word);
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_pc_known = 1'b1; m_held = 1'b0; m_wait = 1'b0;
        end else if (rd) begin
            if (e_req && !rdy_eff) begin
                m_wait = 1'b1; m_target = rpc;
            end else begin
                m_pc = rpc; m_wait = 1'b0; m_held = 1'b0;
            end
        end else if (m_wait) begin
            if (rdy_eff) begin m_pc = m_target; m_wait = 1'b0; end
        end else if (m_held) begin
            if (!s) begin m_pc = m_pc + 32'd4; m_held = 1'b0; end
        end else if (rdy_eff) begin
            if (s) begin m_held = 1'b1; m_word = rdat; end
            else m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        @(posedge clk); #1;

        // Reset, then back-to-back responses with rdata = addr.
        step(1, 0, 0, 0, 1, 32'h0);
        step(1, 1, 1, 32'h80, 1, 32'h0);
        check("first_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'(i * 4));
        check("pc_after_four", imem_addr, 32'd16);

        // Response at addr 8 delayed three cycles.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h4);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0);
        check("delayed_addr", imem_addr, 32'd8);
        check("delayed_adder1", adder1, 32'd12);
        step(0, 0, 0, 0, 1, 32'h8);

        // Stall on the addr-4 response.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
        check("hold_req", {31'd0, imem_req}, 32'd0);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        check("after_hold_addr", imem_addr, 32'd8);

        // Redirect while the addr-8 request is pending.
        step(0, 0, 1, 32'h100, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h1234_5678);
        check("drain_target", imem_addr, 32'h100);

        // Redirect together with stall while holding.
        step(0, 1, 0, 0, 1, 32'hCAFE_0001);
        step(0, 1, 1, 32'h40, 0, 32'h0);
        check("hold_redirect", imem_addr, 32'h40);

        // PC wrap, then reset in the middle of a drain.
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        check("wrap_adder1", adder1, 32'h0);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 1, 32'h200, 0, 32'h0);
        step(1, 0, 1, 32'h300, 1, 32'h0);
        check("reset_drain_addr", imem_addr, RESET_PC);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), rpc, ($urandom_range(0, 1) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
